// File: rtl/eth_port_arbiter.sv
// rtl/eth_port_arbiter.sv - per-output round-robin arbiter with packet ownership and idle watchdog
module eth_port_arbiter #(
  parameter  int NUM_PORTS = 2,
  parameter  int MAX_IDLE  = 1024,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS*PW-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]    beat,
  input  logic [NUM_PORTS-1:0]    beat_end,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [NUM_PORTS-1:0]    out_busy,
  output logic [NUM_PORTS*PW-1:0] out_src,
  output logic [NUM_PORTS-1:0]    timeout
);

  localparam int            CW       = (MAX_IDLE > 0) ? $clog2(MAX_IDLE + 1) : 1;
  localparam bit            WD_EN    = (MAX_IDLE > 0);
  localparam logic [CW-1:0] CNT_LAST = (MAX_IDLE > 0) ? CW'(MAX_IDLE - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q [NUM_PORTS];
  logic [PW-1:0]           ptr_q   [NUM_PORTS];
  logic [CW-1:0]           cnt_q   [NUM_PORTS];
  logic [NUM_PORTS-1:0]    grant_q;
  logic [NUM_PORTS-1:0]    busy_q;
  logic [NUM_PORTS*PW-1:0] src_q;
  logic [NUM_PORTS-1:0]    timeout_q;

  logic [NUM_PORTS-1:0]    win_found;
  logic [PW-1:0]           win_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]    owner_beat;
  logic [NUM_PORTS-1:0]    owner_end;
  logic [NUM_PORTS-1:0]    wd_fire;

  // Round-robin winner search per output plus owner release conditions
  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      win_found[j] = 1'b0;
      win_idx[j]   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = (int'(ptr_q[j]) + k) % NUM_PORTS;
        if (!win_found[j] && req[idx] && !grant_q[idx] &&
            (req_dest[idx*PW +: PW] == PW'(j))) begin
          win_found[j] = 1'b1;
          win_idx[j]   = PW'(idx);
        end
      end
      owner_beat[j] = beat[src_q[j*PW +: PW]];
      owner_end[j]  = owner_beat[j] && beat_end[src_q[j*PW +: PW]];
      wd_fire[j]    = WD_EN && !owner_beat[j] && (cnt_q[j] == CNT_LAST);
    end
  end

  // Per-output IDLE/BUSY state machines with registered grant/busy/src/timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q   <= '0;
      busy_q    <= '0;
      src_q     <= '0;
      timeout_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_q[j] <= IDLE;
        ptr_q[j]   <= PW'(NUM_PORTS - 1);
        cnt_q[j]   <= '0;
      end
    end else begin
      timeout_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        case (state_q[j])
          IDLE: begin
            if (win_found[j]) begin
              state_q[j]           <= BUSY;
              ptr_q[j]             <= win_idx[j];
              grant_q[win_idx[j]]  <= 1'b1;
              busy_q[j]            <= 1'b1;
              src_q[j*PW +: PW]    <= win_idx[j];
              cnt_q[j]             <= '0;
            end
          end
          BUSY: begin
            if (owner_end[j] || wd_fire[j]) begin
              state_q[j]                  <= IDLE;
              grant_q[src_q[j*PW +: PW]]  <= 1'b0;
              busy_q[j]                   <= 1'b0;
              src_q[j*PW +: PW]           <= '0;
              timeout_q[j]                <= !owner_end[j];
              cnt_q[j]                    <= '0;
            end else if (owner_beat[j]) begin
              cnt_q[j] <= '0;
            end else if (WD_EN) begin
              cnt_q[j] <= cnt_q[j] + 1'b1;
            end
          end
          default: state_q[j] <= IDLE;
        endcase
      end
    end
  end

  assign grant    = grant_q;
  assign out_busy = busy_q;
  assign out_src  = src_q;
  assign timeout  = timeout_q;

endmodule
